// File: rtl/coco_spi_slave.sv
// coco_spi_slave: SPI mode-0 slave front end for the CoCo FDC CPLD.
// Brings SCK/MOSI/SSEL into the clock_50 domain, assembles MOSI bytes into
// one-cycle strobes for the FDC/SRAM arbiter and shifts the arbiter's byte
// out on MISO, MSB first.
// Optional build macro: SPI_MISO_TRISTATE_EN -- MISO floats while no frame
// is active; without it MISO is always driven (0 between frames).
module coco_spi_slave #(
    parameter int SYNC_STAGES = 3
) (
    input  logic       clock_50,
    input  logic       reset,
    input  logic       SCK,
    input  logic       MOSI,
    input  logic       SSEL,
    output logic       MISO,
    output logic       byte_received,
    output logic [7:0] byte_data_received,
    input  logic [7:0] byte_send,
    input  logic       send_latch,
    output logic       frame_active,
    output logic [7:0] byte_count,
    output logic       tx_underrun
);

    // Synchronizer chains: index 0 is the newest sample.
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] ssel_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    // A 1 in prime_q[i] means ssel_sync_q[i] holds a real pin sample rather
    // than the reset preset, so a held-low SSEL across reset is not mistaken
    // for a fresh frame start.
    logic [SYNC_STAGES-1:0] prime_q;

    logic       frame_active_q, frame_active_d;
    logic [2:0] bitcnt_q,       bitcnt_d;
    logic [7:0] byte_count_q,   byte_count_d;
    logic [7:0] rxshift_q,      rxshift_d;
    logic [7:0] txshift_q,      txshift_d;
    logic [7:0] rx_data_q,      rx_data_d;
    logic       rx_stb_q,       rx_stb_d;
    logic       underrun_q,     underrun_d;

    logic       sck_rise;
    logic       sck_fall;
    logic       ssel_fall;
    logic       ssel_rise;
    logic       mosi_bit;
    logic [7:0] load_val;

    // Pin synchronizers with their reset presets (SCK low, SSEL high, MOSI low).
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            sck_sync_q  <= '0;
            ssel_sync_q <= '1;
            mosi_sync_q <= '0;
            prime_q     <= '0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
            ssel_sync_q <= {ssel_sync_q[SYNC_STAGES-2:0], SSEL};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            prime_q     <= {prime_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sck_rise  =  sck_sync_q[SYNC_STAGES-2] & ~sck_sync_q[SYNC_STAGES-1];
    assign sck_fall  = ~sck_sync_q[SYNC_STAGES-2] &  sck_sync_q[SYNC_STAGES-1];
    assign ssel_fall =  prime_q[SYNC_STAGES-1] &  ssel_sync_q[SYNC_STAGES-1]
                      & ~ssel_sync_q[SYNC_STAGES-2];
    assign ssel_rise = ~ssel_sync_q[SYNC_STAGES-1] & ssel_sync_q[SYNC_STAGES-2];
    // MOSI changes on SCK fall in mode 0, so it is long settled at the rise.
    assign mosi_bit  = mosi_sync_q[SYNC_STAGES-1];
    assign load_val  = send_latch ? byte_send : 8'h00;

    // Frame, bit/byte counting and shift-register next-state logic.
    always_comb begin
        frame_active_d = frame_active_q;
        bitcnt_d       = bitcnt_q;
        byte_count_d   = byte_count_q;
        rxshift_d      = rxshift_q;
        txshift_d      = txshift_q;
        rx_data_d      = rx_data_q;
        rx_stb_d       = 1'b0;
        underrun_d     = 1'b0;

        if (ssel_fall) begin
            // Also covers a fall seen while a frame is still open.
            frame_active_d = 1'b1;
            bitcnt_d       = 3'd0;
            byte_count_d   = 8'h00;
            txshift_d      = load_val;
            underrun_d     = ~send_latch;
        end else if (frame_active_q) begin
            if (sck_rise) begin
                rxshift_d = {rxshift_q[6:0], mosi_bit};
                bitcnt_d  = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    rx_data_d  = {rxshift_q[6:0], mosi_bit};
                    rx_stb_d   = 1'b1;
                    if (byte_count_q != 8'hFF) begin
                        byte_count_d = byte_count_q + 8'd1;
                    end
                    txshift_d  = load_val;
                    underrun_d = ~send_latch;
                end
            end else if (sck_fall && (bitcnt_q != 3'd0)) begin
                // Skipped right after a byte boundary so the reloaded MSB stays.
                txshift_d = {txshift_q[6:0], 1'b0};
            end
            // Frame close wins last, after any byte completed in this cycle.
            if (ssel_rise) begin
                frame_active_d = 1'b0;
                bitcnt_d       = 3'd0;
                txshift_d      = 8'h00;
            end
        end
    end

    // State registers; reset returns everything to idle immediately.
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            frame_active_q <= 1'b0;
            bitcnt_q       <= 3'd0;
            byte_count_q   <= 8'h00;
            rxshift_q      <= 8'h00;
            txshift_q      <= 8'h00;
            rx_data_q      <= 8'h00;
            rx_stb_q       <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            frame_active_q <= frame_active_d;
            bitcnt_q       <= bitcnt_d;
            byte_count_q   <= byte_count_d;
            rxshift_q      <= rxshift_d;
            txshift_q      <= txshift_d;
            rx_data_q      <= rx_data_d;
            rx_stb_q       <= rx_stb_d;
            underrun_q     <= underrun_d;
        end
    end

    assign byte_received      = rx_stb_q;
    assign byte_data_received = rx_data_q;
    assign frame_active       = frame_active_q;
    assign byte_count         = byte_count_q;
    assign tx_underrun        = underrun_q;

`ifdef SPI_MISO_TRISTATE_EN
    assign MISO = frame_active_q ? txshift_q[7] : 1'bz;
`else
    assign MISO = txshift_q[7];
`endif

endmodule

// File: tb/tb_coco_spi_slave.sv
// Self-checking bench for coco_spi_slave (default build, SYNC_STAGES=3).
module tb_coco_spi_slave;

    logic       clock_50 = 1'b0;
    logic       reset    = 1'b0;
    logic       SCK      = 1'b0;
    logic       MOSI     = 1'b0;
    logic       SSEL     = 1'b1;
    logic [7:0] byte_send  = 8'h00;
    logic       send_latch = 1'b0;
    logic       MISO;
    logic       byte_received;
    logic [7:0] byte_data_received;
    logic       frame_active;
    logic [7:0] byte_count;
    logic       tx_underrun;

    coco_spi_slave #(.SYNC_STAGES(3)) dut (
        .clock_50           (clock_50),
        .reset              (reset),
        .SCK                (SCK),
        .MOSI               (MOSI),
        .SSEL               (SSEL),
        .MISO               (MISO),
        .byte_received      (byte_received),
        .byte_data_received (byte_data_received),
        .byte_send          (byte_send),
        .send_latch         (send_latch),
        .frame_active       (frame_active),
        .byte_count         (byte_count),
        .tx_underrun        (tx_underrun)
    );

    always #10 clock_50 = ~clock_50;

    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] last_rx  = 8'h00;
    logic       prev_br  = 1'b0;
    int         obs_und  = 0;
    int         exp_und  = 0;
    int         exp_cnt  = 0;
    logic [7:0] cur_tx   = 8'h00;
    logic [7:0] nxt_tx   = 8'h00;
    logic [7:0] got      = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare: strobes against queued bytes, held data otherwise.
    always @(negedge clock_50) begin
        if (!reset) begin
            last_rx = 8'h00;
            prev_br = 1'b0;
        end else begin
            if (byte_received === 1'b1) begin
                check("strobe_width", prev_br, 0);
                check("strobe_expected", (exp_rx.size() != 0), 1);
                if (exp_rx.size() != 0) begin
                    last_rx = exp_rx.pop_front();
                    check("rx_byte", byte_data_received, last_rx);
                end
            end else begin
                check("rx_hold", byte_data_received, last_rx);
            end
            if (tx_underrun === 1'b1) obs_und++;
            prev_br = byte_received;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock_50);
            #2;
        end
    endtask

    task automatic start_frame();
        obs_und = 0;
        exp_und = 0;
        exp_cnt = 0;
        SSEL    = 1'b0;
        cur_tx  = send_latch ? byte_send : 8'h00;
        exp_und += send_latch ? 0 : 1;
        tick(6);
        check("frame_active_on", frame_active, 1);
        check("byte_count_start", byte_count, 0);
    endtask

    // Host shifts nbits of m; a full byte's MISO is compared with the loaded byte.
    task automatic xfer_byte(input logic [7:0] m, input int nbits, input bit close_last,
                             input int plo, input int phi);
        logic [7:0] rx;
        rx = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            MOSI = m[7-b];
            tick(plo);
            rx  = {rx[6:0], MISO};
            SCK = 1'b1;
            if (b == 7) begin
                if (close_last) SSEL = 1'b1;
                exp_rx.push_back(m);
                if (exp_cnt < 255) exp_cnt++;
                nxt_tx = send_latch ? byte_send : 8'h00;
                exp_und += send_latch ? 0 : 1;
            end
            tick(phi);
            SCK = 1'b0;
        end
        if (nbits == 8) begin
            check("miso_byte", rx, cur_tx);
            got    = rx;
            cur_tx = nxt_tx;
        end
    endtask

    task automatic end_frame();
        SSEL = 1'b1;
        tick(8);
        check("frame_active_off", frame_active, 0);
        check("byte_count_end", byte_count, exp_cnt);
        check("miso_idle", MISO, 0);
        check("rx_all_strobed", exp_rx.size(), 0);
        check("underrun_count", obs_und, exp_und);
        tick(4);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit cl;
        tick(3);
        check("rst_miso", MISO, 0);
        check("rst_byte_received", byte_received, 0);
        check("rst_byte_data", byte_data_received, 8'h00);
        check("rst_frame_active", frame_active, 0);
        check("rst_byte_count", byte_count, 0);
        check("rst_tx_underrun", tx_underrun, 0);
        reset = 1'b1;
        tick(6);

        // Two bytes in, 0x3C then 0xC3 out, no underrun.
        send_latch = 1'b1;
        byte_send  = 8'h3C;
        start_frame();
        byte_send  = 8'hC3;
        xfer_byte(8'h01, 8, 1'b0, 6, 6);
        check("plan_miso_b1", got, 8'h3C);
        xfer_byte(8'hA5, 8, 1'b0, 6, 6);
        check("plan_miso_b2", got, 8'hC3);
        end_frame();
        check("plan_rx_last", byte_data_received, 8'hA5);
        check("plan_count2", byte_count, 8'd2);
        check("plan_no_underrun", obs_und, 0);

        // Frame starts with nothing latched: zeros out, one underrun.
        send_latch = 1'b0;
        byte_send  = 8'hFF;
        start_frame();
        send_latch = 1'b1;
        byte_send  = 8'h55;
        xfer_byte(8'h6D, 8, 1'b0, 6, 7);
        check("plan_miso_zero", got, 8'h00);
        end_frame();
        check("plan_one_underrun", obs_und, 1);

        // Partial byte discarded, next frame's byte intact.
        start_frame();
        xfer_byte(8'h99, 5, 1'b0, 6, 6);
        end_frame();
        start_frame();
        xfer_byte(8'h7E, 8, 1'b0, 6, 6);
        end_frame();
        check("plan_after_partial", byte_data_received, 8'h7E);

        // Reset mid-byte, SSEL held low through release.
        byte_send = 8'h81;
        start_frame();
        xfer_byte(8'hF0, 4, 1'b0, 6, 6);
        reset = 1'b0;
        tick(1);
        check("midrst_miso", MISO, 0);
        check("midrst_byte_received", byte_received, 0);
        check("midrst_byte_data", byte_data_received, 8'h00);
        check("midrst_frame_active", frame_active, 0);
        check("midrst_byte_count", byte_count, 0);
        check("midrst_tx_underrun", tx_underrun, 0);
        tick(3);
        exp_rx.delete();
        obs_und = 0;
        exp_und = 0;
        exp_cnt = 0;
        reset = 1'b1;
        tick(12);
        check("no_start_without_edge", frame_active, 0);
        SSEL = 1'b1;
        tick(6);
        byte_send = 8'h5A;
        start_frame();
        xfer_byte(8'h12, 8, 1'b0, 6, 6);
        check("postrst_miso", got, 8'h5A);
        xfer_byte(8'h34, 8, 1'b0, 6, 6);
        end_frame();
        check("postrst_count", byte_count, 8'd2);

        // 8th SCK rise and SSEL rise on the same edge.
        start_frame();
        xfer_byte(8'h3A, 8, 1'b1, 6, 6);
        end_frame();
        check("coincident_byte", byte_data_received, 8'h3A);

        // Randomized frames.
        for (int f = 0; f < 10; f++) begin
            send_latch = ($urandom_range(0, 3) != 0);
            byte_send  = 8'($urandom);
            start_frame();
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                send_latch = ($urandom_range(0, 3) != 0);
                byte_send  = 8'($urandom);
                cl = (k == n - 1) && ($urandom_range(0, 2) == 0);
                xfer_byte(8'($urandom), 8, cl, $urandom_range(6, 9), $urandom_range(6, 9));
            end
            end_frame();
        end

        // Long frame: byte_count saturates at 0xFF.
        send_latch = 1'b1;
        byte_send  = 8'($urandom);
        start_frame();
        for (int k = 0; k < 257; k++) begin
            byte_send = 8'($urandom);
            xfer_byte(8'($urandom), 8, 1'b0, 6, 6);
        end
        end_frame();
        check("count_saturated", byte_count, 8'hFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/coco_spi_slave.md
# coco_spi_slave

SPI slave front end for the CoCo FDC CPLD. It sits directly upstream of the FDC/SRAM arbiter. It brings the host's SCK/MOSI/SSEL into the 50 MHz domain, assembles MOSI bytes and hands each one to the arbiter as a one-cycle strobe. It also shifts the arbiter's latched read byte out on MISO.

## Interface
Parameters:
- SYNC_STAGES, 3: synchronizer depth for SCK/SSEL/MOSI, minimum 2; the last two stages feed edge detect.

Ports:
- clock_50  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low
- SCK  in  1  SPI clock from host, mode 0 (CPOL=0, CPHA=0), ≤4 MHz
- MOSI  in  1  host data, MSB first
- SSEL  in  1  slave select, active-low
- MISO  out  1  slave data, MSB first
- byte_received  out  1  one-cycle strobe, byte_data_received valid
- byte_data_received  out  8  last complete MOSI byte, held until next strobe
- byte_send  in  8  byte to transmit next
- send_latch  in  1  level; byte_send valid and may be loaded
- frame_active  out  1  synchronized SSEL asserted
- byte_count  out  8  complete bytes in current frame, saturates at 0xFF
- tx_underrun  out  1  one-cycle strobe: a byte slot began with send_latch low

## Operation
- Synchronize SCK, SSEL and MOSI through SYNC_STAGES flops. Edge detect compares the last two stages. sck_rise and sck_fall are ignored unless frame_active is 1.
- SSEL falling detected:
  - set frame_active, bitcnt=0, byte_count=0;
  - load txshift = send_latch ? byte_send : 8'h00;
  - pulse tx_underrun if send_latch is 0.
- sck_rise:
  - rxshift = {rxshift[6:0], MOSI_sync}; bitcnt = bitcnt+1 (3 bits, wraps 7→0).
  - On the rise that wraps bitcnt to 0:
    - byte_data_received = {rxshift[6:0], MOSI_sync};
    - byte_received = 1 next cycle;
    - byte_count = byte_count+1 (saturating);
    - reload txshift from byte_send/send_latch as above, pulsing tx_underrun if send_latch is 0.
- sck_fall: if bitcnt != 0, txshift = {txshift[6:0], 1'b0}. The fall following a byte-completing rise does not shift, so the reloaded MSB survives to the next rise.
- MISO = txshift[7].
- SSEL rising detected: clear frame_active and bitcnt. Partial bits are discarded with no strobe. byte_count holds its value until the next frame start.
- byte_send is sampled only at load instants. The arbiter must present the next byte with send_latch high before the next byte slot begins.

## Timing
- Reset values:
  - MISO=0 (Z with macro); byte_received=0; byte_data_received=8'h00; frame_active=0; byte_count=0; tx_underrun=0;
  - txshift=rxshift=0, bitcnt=0;
  - synchronizers preset to SCK=0, SSEL=1, MOSI=0.
- Latency, pin edge to action: SYNC_STAGES or SYNC_STAGES+1 clock_50 cycles.
- byte_received asserts exactly one cycle after the 8th sck_rise is detected. It never stays high for 2 consecutive cycles.
- SCK high and low phases must each be ≥ SYNC_STAGES+2 clock_50 periods (4 MHz gives 6 cycles per phase).
- Simultaneous 8th sck_rise and SSEL rising in the same cycle: the byte completes and strobes, then the frame closes.
- reset asserted mid-frame: all state returns to reset values immediately. The frame is lost with no strobe. After release, a new SSEL falling edge is required.
- SSEL falling edge while frame_active (glitch with no rise seen): treated as a new frame start.

## Configuration
- SPI_MISO_TRISTATE_EN defined: MISO = frame_active ? txshift[7] : 1'bz. This allows a shared MISO line.
- Undefined: MISO always driven with txshift[7]. It reads 0 between frames, since txshift is cleared on frame end.

## Test plan
- Reset, then frame with MOSI 0x01 0xA5 -> two byte_received strobes, byte_data_received 0x01 then 0xA5; byte_count=2.
- send_latch=1, byte_send=0x3C at SSEL fall; change to 0xC3 before byte 2 -> MISO bits 0x3C then 0xC3, no tx_underrun.
- send_latch=0 at frame start -> MISO byte 0x00, one tx_underrun strobe.
- SSEL deasserted after 5 SCK rises -> no byte_received; the next frame's first byte (0x7E) is received intact.
- reset pulsed at bit 4 of a byte -> all outputs at reset values, no strobe; the next full frame works.
- 8th SCK rise coincident with SSEL rise (same clock_50 edge at pins) -> strobe with the correct byte, then frame_active=0.
